// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format (5-9 data bits, none/odd/even parity,
// 1-2 stop bits) fed by a small circular FIFO; bit timing comes from the clken baud tick.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 clken,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 full,
  output logic                 overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           idx;
  logic                 scnt;
  logic                 empty, push, pop, last_stop;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = wr_en && !full;
  assign last_stop = (state == S_STOP) && (scnt == 1'(STOP_BITS - 1));
  // A pop only happens on a tick that launches a new start bit.
  assign pop       = clken && !empty && ((state == S_IDLE) || last_stop);
  assign tx_busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Shift register presents the next data bit at bit 0; parity is captured at pop time.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= mem[rptr];
      par_bit <= parity_of(mem[rptr]);
    end else if (clken && (state == S_START || state == S_DATA)) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      idx   <= '0;
      scnt  <= 1'b0;
    end else if (clken) begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            tx    <= 1'b0;
            state <= S_START;
          end else begin
            tx <= 1'b1;
          end
        end
        S_START: begin
          tx    <= shreg[0];
          idx   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          if (idx < 4'(DATA_BITS - 1)) begin
            idx <= idx + 4'd1;
            tx  <= shreg[0];
          end else if (PARITY != 0) begin
            tx    <= par_bit;
            state <= S_PAR;
          end else begin
            tx    <= 1'b1;
            scnt  <= 1'b0;
            state <= S_STOP;
          end
        end
        S_PAR: begin
          tx    <= 1'b1;
          scnt  <= 1'b0;
          state <= S_STOP;
        end
        S_STOP: begin
          if (!last_stop) begin
            scnt <= scnt + 1'b1;
            tx   <= 1'b1;
          end else if (!empty) begin
            tx    <= 1'b0;
            state <= S_START;
          end else begin
            tx    <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2) checked tick by tick against
// a queue of expected frame bits built from each written word.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       wr_en_a = 1'b0;
  logic       wr_en_bc = 1'b0;
  logic       clken = 1'b0;
  logic [2:0] tx_w, busy_w, full_w, ovf_w;

  typedef struct {
    logic b;
    int   wcyc;
  } exp_t;

  exp_t q[3][$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ticks = 0;
  int   period = 0;
  int   ccnt = 0;
  logic ck_s, r_s;
  exp_t e;
  logic last_bit[3];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en_a), .clken(clken),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .full(full_w[0]), .overflow(ovf_w[0]));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din[6:0]), .wr_en(wr_en_bc), .clken(clken),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .full(full_w[1]), .overflow(ovf_w[1]));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din[6:0]), .wr_en(wr_en_bc), .clken(clken),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .full(full_w[2]), .overflow(ovf_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nbits(input int i);
    return (i == 0) ? 8 : 7;
  endfunction
  function automatic int pmode(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int sbits(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic push_word(input int i, input logic [7:0] d, input int wc);
    logic p;
    exp_t x;
    p = 1'b0;
    x.wcyc = wc;
    x.b = 1'b0;
    q[i].push_back(x);
    for (int k = 0; k < nbits(i); k++) begin
      x.b = d[k];
      p = p ^ d[k];
      q[i].push_back(x);
    end
    if (pmode(i) == 1) begin
      x.b = ~p;
      q[i].push_back(x);
    end else if (pmode(i) == 2) begin
      x.b = p;
      q[i].push_back(x);
    end
    for (int k = 0; k < sbits(i); k++) begin
      x.b = 1'b1;
      q[i].push_back(x);
    end
  endtask

  // Drives one write to instance A at the current negedge and returns at the next negedge.
  task automatic write_a(input logic [7:0] d, input bit accepted);
    din = d;
    wr_en_a = 1'b1;
    if (accepted) push_word(0, d, cyc + 1);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0 || busy_w != 3'b000)
           && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < maxc), 1);
  endtask

  task automatic wait_busy_ticks(input int n);
    int c;
    int t0;
    c = 0;
    while (!busy_w[0] && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("wait_busy", 32'(busy_w[0]), 1);
    t0 = ticks;
    c = 0;
    while (ticks < t0 + n && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("wait_ticks", 32'(ticks >= t0 + n), 1);
  endtask

  always @(negedge clk) begin
    if (period == 0) begin
      clken = 1'b0;
      ccnt = 0;
    end else begin
      clken = (ccnt == period - 1);
      ccnt = (ccnt + 1) % period;
    end
  end

  always @(posedge clk) begin
    ck_s = clken;
    r_s = rst_n;
    cyc++;
    #1;
    if (r_s && ck_s) begin
      ticks++;
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) begin
          check($sformatf("frame_expected%0d", i), 32'(q[i].size() != 0), 1);
          if (q[i].size() != 0) begin
            e = q[i].pop_front();
            last_bit[i] = e.b;
            check($sformatf("bit%0d", i), 32'(tx_w[i]), 32'(e.b));
          end
        end else begin
          check($sformatf("idle_tx%0d", i), 32'(tx_w[i]), 1);
          if (q[i].size() != 0 && q[i][0].wcyc < cyc)
            check($sformatf("start_late%0d", i), 32'(busy_w[i]), 1);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx_w), 32'h7);
    check("rst_busy", 32'(busy_w), 0);
    check("rst_full", 32'(full_w), 0);
    check("rst_ovf", 32'(ovf_w), 0);
    rst_n = 1'b1;

    // 7E2 and 7O2 frames of 0x41
    period = 4;
    @(negedge clk);
    din = 8'h41;
    wr_en_bc = 1'b1;
    push_word(1, 8'h41, cyc + 1);
    push_word(2, 8'h41, cyc + 1);
    @(negedge clk);
    wr_en_bc = 1'b0;
    drain(1000);

    // 8N1 single word at 16 cycles per bit
    period = 16;
    write_a(8'hA5, 1'b1);
    wr_en_a = 1'b0;
    drain(1000);

    // back-to-back frames
    period = 4;
    write_a(8'h00, 1'b1);
    write_a(8'hFF, 1'b1);
    wr_en_a = 1'b0;
    drain(1000);

    // overflow with ticks stopped
    period = 0;
    repeat (2) @(negedge clk);
    write_a(8'h11, 1'b1);
    write_a(8'h22, 1'b1);
    write_a(8'h33, 1'b1);
    check("full_after3", 32'(full_w[0]), 0);
    write_a(8'h44, 1'b1);
    check("full_after4", 32'(full_w[0]), 1);
    check("ovf_before5", 32'(ovf_w[0]), 0);
    write_a(8'h55, 1'b0);
    wr_en_a = 1'b0;
    check("ovf_pulse", 32'(ovf_w[0]), 1);
    check("full_hold", 32'(full_w[0]), 1);
    @(negedge clk);
    check("ovf_clear", 32'(ovf_w[0]), 0);
    period = 4;
    drain(2000);
    check("full_drained", 32'(full_w[0]), 0);

    // stall mid-DATA
    write_a(8'hC3, 1'b1);
    wr_en_a = 1'b0;
    wait_busy_ticks(2);
    period = 0;
    repeat (50) @(negedge clk);
    check("stall_tx", 32'(tx_w[0]), 32'(last_bit[0]));
    check("stall_busy", 32'(busy_w[0]), 1);
    period = 4;
    drain(1000);

    // reset during the third data bit with two words queued
    write_a(8'h5A, 1'b1);
    write_a(8'h5B, 1'b1);
    write_a(8'h5C, 1'b1);
    wr_en_a = 1'b0;
    wait_busy_ticks(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q[0].delete();
    check("rstmid_tx", 32'(tx_w[0]), 1);
    check("rstmid_busy", 32'(busy_w[0]), 0);
    check("rstmid_full", 32'(full_w[0]), 0);
    repeat (200) @(negedge clk);
    check("rstmid_quiet", 32'(busy_w[0]), 0);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
